// File: rtl/break_clock_ctrl_pkg.sv
// break_clock_ctrl_pkg: shared IO addresses, run-control state and halt-cause encodings
package break_clock_ctrl_pkg;
   localparam logic [31:0] DBG_CTRL_ADDRESS   = 32'hFFFF_0100;
   localparam logic [31:0] DBG_STATUS_ADDRESS = 32'hFFFF_0104;
   localparam logic [31:0] DBG_HPC_ADDRESS    = 32'hFFFF_0108;
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_STEP  = 2'd2,
      ST_LEAVE = 2'd3
   } state_t;
   typedef enum logic [2:0] {
      CAUSE_NONE  = 3'd0,
      CAUSE_BREAK = 3'd1,
      CAUSE_KEY   = 3'd2,
      CAUSE_BUS   = 3'd3,
      CAUSE_STEP  = 3'd4
   } cause_t;
endpackage

// File: rtl/break_clock_ctrl_key_debounce.sv
// key_debounce: synchronises an active-low key, debounces it and emits one pulse per press
// Ports: i_clk clock; i_rst sync reset; i_key_n raw async key (low = pressed); o_press 1-cycle press pulse
module key_debounce
   import break_clock_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_level, r_press, w_diff, w_accept;
   assign w_diff   = r_sync[1] != r_level;
   // the DEBOUNCE_CYCLES-th consecutive differing sample commits the new level
   assign w_accept = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign o_press  = r_press;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync  <= 2'b11;
         r_cnt   <= '0;
         r_level <= 1'b1;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_key_n};
         r_cnt   <= (w_diff && !w_accept) ? r_cnt + 1'b1 : '0;
         r_level <= w_accept ? r_sync[1] : r_level;
         r_press <= w_accept && r_level;
      end
   end
endmodule

// File: rtl/break_clock_ctrl.sv
// break_clock_ctrl: debug run control gating the CPU clock enable to halt, single-step and resume
// Ports: iCLK clock; Reset sync active-high reset; iBreak breakpoint hit; iKEY active-low keys
//        ([0] halt, [1] step, [3] resume); iPC current PC; oCPU_CE CPU clock enable; oHalted halt flag;
//        wReadEnable/wWriteEnable/wByteEnable/wAddress/wWriteData/wReadData IO bus (CTRL, STATUS, HPC)
module break_clock_ctrl
   import break_clock_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit START_HALTED    = 1'b0,
   parameter int CNT_W           = 16
) (
   input  logic        iCLK,
   input  logic        Reset,
   input  logic        iBreak,
   input  logic [3:0]  iKEY,
   input  logic [31:0] iPC,
   output logic        oCPU_CE,
   output logic        oHalted,
   input  logic        wReadEnable,
   input  logic        wWriteEnable,
   input  logic [3:0]  wByteEnable,
   input  logic [31:0] wAddress,
   input  logic [31:0] wWriteData,
   output logic [31:0] wReadData
);
   state_t           r_state, w_state;
   cause_t           r_cause, w_cause;
   logic [31:0]      r_hpc;
   logic [CNT_W-1:0] r_step_cnt, r_halt_cnt;
   logic [2:0]       r_cmd, w_press;
   logic             r_brk_en, r_pend_key, r_pend_bus;
   logic             w_wr, w_brk, w_halt_key, w_halt_bus, w_step, w_resume, w_cap, w_hinc, w_sinc, w_unused;
   for (genvar g = 0; g < 3; g++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
         .i_clk   (iCLK),
         .i_rst   (Reset),
         .i_key_n (iKEY[g == 2 ? 3 : g]),
         .o_press (w_press[g])
      );
   end
   assign w_unused   = ^{iKEY[2], wByteEnable[3:1], wWriteData[31:4]};
   assign w_wr       = wWriteEnable && (wAddress == DBG_CTRL_ADDRESS) && wByteEnable[0];
   assign w_brk      = iBreak && r_brk_en;
   // a halt request that arrived during LEAVE is replayed once in RUN
   assign w_halt_key = w_press[0] || r_pend_key;
   assign w_halt_bus = r_cmd[0] || r_pend_bus;
   assign w_step     = w_press[1] || r_cmd[1];
   assign w_resume   = w_press[2] || r_cmd[2];
   assign oCPU_CE    = r_state != ST_HALT;
   assign oHalted    = r_state == ST_HALT;
   assign wReadData  = !wReadEnable                     ? {32{1'bz}} :
                       (wAddress == DBG_CTRL_ADDRESS)   ? {28'b0, r_brk_en, 3'b0} :
                       (wAddress == DBG_STATUS_ADDRESS) ? {16'(r_step_cnt), 5'b0, r_cause, 6'b0, r_state} :
                       (wAddress == DBG_HPC_ADDRESS)    ? r_hpc : {32{1'bz}};
   always_comb begin
      w_state = r_state;
      w_cause = r_cause;
      w_cap   = 1'b0;
      w_hinc  = 1'b0;
      w_sinc  = 1'b0;
      case (r_state)
         ST_RUN: if (w_brk || w_halt_key || w_halt_bus) begin
            w_state = ST_HALT;
            w_cause = w_brk ? CAUSE_BREAK : w_halt_key ? CAUSE_KEY : CAUSE_BUS;
            w_cap   = 1'b1;
            w_hinc  = 1'b1;
         end
         ST_HALT: w_state = w_step ? ST_STEP : w_resume ? ST_LEAVE : ST_HALT;
         ST_STEP: begin
            w_state = ST_HALT;
            w_cause = CAUSE_STEP;
            w_cap   = 1'b1;
            w_sinc  = 1'b1;
         end
         default: w_state = ST_RUN;
      endcase
   end
   always_ff @(posedge iCLK) begin
      if (Reset) begin
         r_state    <= START_HALTED ? ST_HALT : ST_RUN;
         r_cause    <= CAUSE_NONE;
         r_hpc      <= '0;
         r_step_cnt <= '0;
         r_halt_cnt <= '0;
         r_brk_en   <= 1'b1;
         r_cmd      <= '0;
         r_pend_key <= 1'b0;
         r_pend_bus <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cause    <= w_cause;
         r_hpc      <= w_cap ? iPC : r_hpc;
         r_step_cnt <= r_step_cnt + CNT_W'(w_sinc);
         r_halt_cnt <= r_halt_cnt + CNT_W'(w_hinc);
         r_brk_en   <= w_wr ? wWriteData[3] : r_brk_en;
         r_cmd      <= w_wr ? wWriteData[2:0] : 3'b0;
         r_pend_key <= (r_state == ST_LEAVE) && w_press[0];
         r_pend_bus <= (r_state == ST_LEAVE) && r_cmd[0];
      end
   end
endmodule

// File: tb/tb_break_clock_ctrl.sv
// tb_break_clock_ctrl: table vectors, corner-case sequences and a randomized reference-model run
module tb_break_clock_ctrl;
   import break_clock_ctrl_pkg::*;
   localparam int D = 4;
   logic        iCLK = 1'b0, Reset = 1'b1, iBreak = 1'b0;
   logic [3:0]  iKEY = 4'hF;
   logic [31:0] iPC = '0;
   logic        oCPU_CE, oHalted;
   logic        wReadEnable = 1'b1, wWriteEnable = 1'b0;
   logic [3:0]  wByteEnable = 4'hF;
   logic [31:0] wAddress = DBG_STATUS_ADDRESS, wWriteData = '0;
   wire  [31:0] wReadData;
   int          n_tests = 0, n_fail = 0;

   break_clock_ctrl #(.DEBOUNCE_CYCLES(D), .START_HALTED(1'b0), .CNT_W(16)) dut (
      .iCLK(iCLK), .Reset(Reset), .iBreak(iBreak), .iKEY(iKEY), .iPC(iPC),
      .oCPU_CE(oCPU_CE), .oHalted(oHalted),
      .wReadEnable(wReadEnable), .wWriteEnable(wWriteEnable), .wByteEnable(wByteEnable),
      .wAddress(wAddress), .wWriteData(wWriteData), .wReadData(wReadData)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic        we;
      logic [31:0] wd;
      logic [31:0] addr;
      logic        brk;
      logic [31:0] pc;
      logic        ce;
      logic        hl;
      logic [31:0] rd;
   } vec_t;
   vec_t tbl[6];

   // reference model state: 0 run, 1 halt, 2 step, 3 leave
   logic [1:0]  m_st;
   logic [2:0]  m_cause, m_cmd;
   logic [31:0] m_hpc;
   logic [15:0] m_scnt;
   logic        m_brk, m_pb;

   task automatic cyc;
      @(posedge iCLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_hiz(input string nm);
      n_tests++;
      if (wReadData !== {32{1'bz}} && wReadData !== 32'h0) begin
         n_fail++;
         $display("FAIL %s: got %h expected high-Z", nm, wReadData);
      end
   endtask

   task automatic rd(input string nm, input logic [31:0] addr, input logic [31:0] exp);
      wAddress = addr;
      #1;
      chk(nm, wReadData, exp);
   endtask

   task automatic wr(input logic [31:0] d);
      wWriteEnable = 1'b1;
      wAddress     = DBG_CTRL_ADDRESS;
      wWriteData   = d;
      cyc;
      wWriteEnable = 1'b0;
      wAddress     = DBG_STATUS_ADDRESS;
   endtask

   task automatic do_reset;
      Reset = 1'b1;
      wWriteEnable = 1'b0;
      iKEY = 4'hF;
      iBreak = 1'b0;
      cyc;
      cyc;
      Reset = 1'b0;
   endtask

   task automatic model_edge;
      logic [2:0] c;
      logic       hb, pb_n;
      c    = m_cmd;
      hb   = c[0] | m_pb;
      pb_n = (m_st == 2'd3) && c[0];
      if (m_st == 2'd0) begin
         if (iBreak && m_brk) begin
            m_st = 2'd1; m_cause = 3'd1; m_hpc = iPC;
         end else if (hb) begin
            m_st = 2'd1; m_cause = 3'd3; m_hpc = iPC;
         end
      end else if (m_st == 2'd1) begin
         m_st = c[1] ? 2'd2 : c[2] ? 2'd3 : 2'd1;
      end else if (m_st == 2'd2) begin
         m_st = 2'd1; m_cause = 3'd4; m_hpc = iPC; m_scnt = m_scnt + 16'd1;
      end else begin
         m_st = 2'd0;
      end
      m_pb = pb_n;
      if (wWriteEnable && wAddress == DBG_CTRL_ADDRESS && wByteEnable[0]) begin
         m_cmd = wWriteData[2:0];
         m_brk = wWriteData[3];
      end else begin
         m_cmd = 3'b0;
      end
   endtask

   initial begin
      int ce_cnt, lv_cnt, t;
      logic [15:0] s;
      tbl[0] = '{1'b0, 32'h0, DBG_STATUS_ADDRESS, 1'b1, 32'h00400010, 1'b0, 1'b1, 32'h00000101};
      tbl[1] = '{1'b0, 32'h0, DBG_HPC_ADDRESS,    1'b0, 32'h00400010, 1'b0, 1'b1, 32'h00400010};
      tbl[2] = '{1'b1, 32'h2, DBG_CTRL_ADDRESS,   1'b0, 32'h00400010, 1'b0, 1'b1, 32'h00000000};
      tbl[3] = '{1'b0, 32'h0, DBG_STATUS_ADDRESS, 1'b0, 32'h00400014, 1'b1, 1'b0, 32'h00000102};
      tbl[4] = '{1'b0, 32'h0, DBG_HPC_ADDRESS,    1'b0, 32'h00400014, 1'b0, 1'b1, 32'h00400014};
      tbl[5] = '{1'b0, 32'h0, DBG_STATUS_ADDRESS, 1'b0, 32'h00400014, 1'b0, 1'b1, 32'h00010401};

      do_reset;
      chk("rst_ce", 32'(oCPU_CE), 32'd1);
      chk("rst_halted", 32'(oHalted), 32'd0);
      rd("rst_status", DBG_STATUS_ADDRESS, 32'h0);
      rd("rst_hpc", DBG_HPC_ADDRESS, 32'h0);
      rd("rst_ctrl", DBG_CTRL_ADDRESS, 32'h8);

      for (int i = 0; i < 6; i++) begin
         wWriteEnable = tbl[i].we;
         wWriteData   = tbl[i].wd;
         wAddress     = tbl[i].addr;
         iBreak       = tbl[i].brk;
         iPC          = tbl[i].pc;
         cyc;
         wWriteEnable = 1'b0;
         chk($sformatf("vec%0d_ce", i), 32'(oCPU_CE), 32'(tbl[i].ce));
         chk($sformatf("vec%0d_halted", i), 32'(oHalted), 32'(tbl[i].hl));
         chk($sformatf("vec%0d_rd", i), wReadData, tbl[i].rd);
      end

      for (int r = 0; r < 3; r++) begin
         iPC = 32'h00400018 + 32'(4 * r);
         wr(32'h2);
         ce_cnt = 0;
         for (int k = 0; k < 5; k++) begin
            cyc;
            ce_cnt += int'(oCPU_CE);
         end
         chk($sformatf("step%0d_ce_cycles", r), 32'(ce_cnt), 32'd1);
      end
      rd("steps_status", DBG_STATUS_ADDRESS, 32'h00040401);
      rd("steps_hpc", DBG_HPC_ADDRESS, 32'h00400020);

      wr(32'h8);
      iBreak = 1'b1;
      iKEY[3] = 1'b0;
      ce_cnt = 0;
      lv_cnt = 0;
      for (int k = 0; k < 10 * D; k++) begin
         cyc;
         ce_cnt += int'(oCPU_CE);
         lv_cnt += int'(wReadData[1:0] == 2'd3);
      end
      chk("resume_ce_cycles", 32'(ce_cnt), 32'd2);
      chk("resume_leave_cycles", 32'(lv_cnt), 32'd1);
      chk("resume_rehalt", 32'(oHalted), 32'd1);
      chk("resume_cause", 32'(wReadData[10:8]), 32'd1);
      iKEY[3] = 1'b1;
      iBreak = 1'b0;
      for (int k = 0; k < 4 * D; k++) cyc;
      chk("release_no_pulse", 32'(oHalted), 32'd1);

      wr(32'h4);
      cyc;
      cyc;
      chk("bus_resume", 32'(oHalted), 32'd0);
      wr(32'h8);
      wr(32'h0);
      rd("brk_en_clear", DBG_CTRL_ADDRESS, 32'h0);
      iBreak = 1'b1;
      ce_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         cyc;
         ce_cnt += int'(oCPU_CE);
      end
      chk("brk_masked_run", 32'(ce_cnt), 32'd5);
      iKEY[0] = 1'b0;
      for (t = 0; t < 4 * D + 8 && !oHalted; t++) cyc;
      chk("key_halt", 32'(oHalted), 32'd1);
      rd("key_halt_status", DBG_STATUS_ADDRESS, 32'h00040201);
      iKEY[0] = 1'b1;
      iBreak = 1'b0;
      for (int k = 0; k < 4 * D; k++) cyc;

      wr(32'h6);
      cyc;
      chk("step_wins_state", 32'(wReadData[1:0]), 32'd2);
      cyc;
      chk("step_wins_status", wReadData, 32'h00050401);
      ce_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         cyc;
         ce_cnt += int'(oCPU_CE);
      end
      chk("step_wins_no_leave", 32'(ce_cnt), 32'd0);

      s = wReadData[31:16];
      iKEY[1] = 1'b0;
      cyc;
      cyc;
      iKEY[1] = 1'b1;
      iKEY[3] = 1'b0;
      cyc;
      cyc;
      iKEY[3] = 1'b1;
      ce_cnt = 0;
      for (int k = 0; k < 4 * D; k++) begin
         cyc;
         ce_cnt += int'(oCPU_CE);
      end
      chk("glitch_ce", 32'(ce_cnt), 32'd0);
      chk("glitch_step_cnt", 32'(wReadData[15:0] == 16'h0401 ? wReadData[31:16] : 16'hFFFF), 32'(s));

      wr(32'h4);
      wr(32'h1);
      for (t = 0; t < 8 && !oHalted; t++) cyc;
      chk("pending_halt", 32'(oHalted), 32'd1);
      chk("pending_cause", 32'(wReadData[10:8]), 32'd3);

      wr(32'h2);
      cyc;
      chk("rst_step_state", 32'(wReadData[1:0]), 32'd2);
      Reset = 1'b1;
      cyc;
      Reset = 1'b0;
      chk("rst_step_ce", 32'(oCPU_CE), 32'd1);
      chk("rst_step_halted", 32'(oHalted), 32'd0);
      rd("rst_step_status", DBG_STATUS_ADDRESS, 32'h0);
      rd("rst_step_hpc", DBG_HPC_ADDRESS, 32'h0);
      wAddress = 32'h0000_0055;
      #1;
      chk_hiz("unmapped_read");
      wReadEnable = 1'b0;
      wAddress = DBG_HPC_ADDRESS;
      #1;
      chk_hiz("no_read_enable");
      wReadEnable = 1'b1;

      do_reset;
      m_st = 2'd0; m_cause = 3'd0; m_cmd = 3'd0; m_hpc = '0; m_scnt = '0; m_brk = 1'b1; m_pb = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         int a;
         logic [31:0] exp_rd;
         logic        mapped;
         iBreak       = ($urandom_range(7) == 0);
         iPC          = $urandom;
         a            = $urandom_range(5);
         wAddress     = a < 3 ? DBG_CTRL_ADDRESS : a == 3 ? DBG_STATUS_ADDRESS : a == 4 ? DBG_HPC_ADDRESS : 32'h0000_0055;
         wReadEnable  = $urandom_range(7) != 0;
         wWriteEnable = $urandom_range(2) == 0;
         wWriteData   = $urandom;
         wByteEnable  = 4'($urandom_range(15));
         model_edge;
         cyc;
         chk("rnd_ce", 32'(oCPU_CE), 32'(m_st != 2'd1));
         chk("rnd_halted", 32'(oHalted), 32'(m_st == 2'd1));
         mapped = wReadEnable && a != 5;
         exp_rd = a < 3 ? {28'b0, m_brk, 3'b0} : a == 3 ? {m_scnt, 5'b0, m_cause, 6'b0, m_st} : m_hpc;
         if (mapped) chk("rnd_read", wReadData, exp_rd);
         else chk_hiz("rnd_read_hiz");
      end
      wWriteEnable = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
